// File: rtl/data_buffer_pkg.sv
// Shared types and helpers for the data_buffer FIFO and its storage array.
package data_buffer_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_buffer_mem.sv
// Storage array for data_buffer: one synchronous write port, one asynchronous read port, no reset.
module data_buffer_mem #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2,
  parameter type         DATA_T = logic
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  DATA_T [WIDTH-1:0]      i_wdata,
  input  logic [AW-1:0]          i_raddr,
  output DATA_T [WIDTH-1:0]      o_rdata
);

  DATA_T [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_buffer.sv
// Parametrised valid/ready FIFO with flush, occupancy, almost-full and state outputs.
// BYPASS=1 collapses it to a single registered stage.
module data_buffer
  import data_buffer_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 4,
  parameter type         DATA_T   = logic,
  parameter bit          BYPASS   = 1'b0,
  parameter int unsigned AF_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  DATA_T [WIDTH-1:0]            i_in_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output DATA_T [WIDTH-1:0]            o_out_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_almost_full,
  output state_t                       o_state
);

  localparam int unsigned D  = BYPASS ? 1 : DEPTH;
  localparam int unsigned PW = (ptr_w(D) == 0) ? 1 : ptr_w(D);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CntFull = CW'(D);

  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
  logic [CW-1:0]     r_count, w_count_d;
  state_t            r_state, w_state_d;
  logic              r_af, w_af_d;
  logic              w_push, w_pop, w_in_ready, w_nonempty;
  DATA_T [WIDTH-1:0] w_rdata, r_hold;

  assign w_nonempty = (r_count != '0);

  always_comb begin
    // Bypass is the only mode allowed a combinational out_ready -> in_ready path.
    w_in_ready = BYPASS ? (!w_nonempty || i_out_ready) : (r_count != CntFull);
    w_push     = i_in_valid & w_in_ready;
    w_pop      = w_nonempty & i_out_ready;
    w_wr_ptr_d = r_wr_ptr;
    w_rd_ptr_d = r_rd_ptr;
    w_count_d  = r_count;
    if (i_flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
    end else begin
      if (w_push) w_wr_ptr_d = (D == 1) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  w_rd_ptr_d = (D == 1) ? '0 : r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + CW'(1);
        2'b01:   w_count_d = r_count - CW'(1);
        default: w_count_d = r_count;
      endcase
    end
  end

  always_comb begin
    w_state_d = BUSY;
    if (w_count_d == '0) begin
      w_state_d = IDLE;
    end else if (w_count_d == CntFull) begin
      w_state_d = FULL;
    end
    w_af_d = (32'(w_count_d) >= AF_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= IDLE;
      r_af     <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
      r_state  <= w_state_d;
      r_af     <= w_af_d;
      // Remember the visible head so out_data holds once the buffer drains.
      if (w_nonempty) r_hold <= w_rdata;
    end
  end

  data_buffer_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (D),
    .AW     (PW),
    .DATA_T (DATA_T)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push & ~i_flush),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_in_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign o_in_ready    = w_in_ready;
  assign o_out_valid   = w_nonempty;
  assign o_out_data    = w_nonempty ? w_rdata : r_hold;
  assign o_count       = r_count;
  assign o_almost_full = r_af;
  assign o_state       = r_state;

endmodule
